// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard constants: scan-code prefixes, Pause tail and controller states.
package ps2_pkg;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;
  localparam logic [7:0] CODE_ERR0 = 8'h00;
  localparam logic [7:0] CODE_ERR1 = 8'hFF;

  // Bytes that follow E1 in the Pause make sequence, first byte in the MSBs
  localparam int          PAUSE_LEN  = 7;
  localparam logic [55:0] PAUSE_TAIL = 56'h14_77_E1_F0_14_F0_77;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EMIT,
    FLUSH,
    PAUSE
  } state_e;

  function automatic logic [7:0] pause_byte(input logic [2:0] idx);
    pause_byte = PAUSE_TAIL[8*(PAUSE_LEN-1-int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/ps2_kbd_ctrl_if.sv
// Key-event valid/ready channel from the keyboard controller to the game logic.
interface ps2_kbd_ctrl_if;

  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       ev_pause;

  modport master (output ev_valid, ev_code, ev_ext, ev_break, ev_pause, input ev_ready);
  modport slave  (input ev_valid, ev_code, ev_ext, ev_break, ev_pause, output ev_ready);

endinterface

// File: rtl/ps2_wdog_tick.sv
// Free-running tick generator: one-cycle pulse every WDOG_CYCLES clocks.
module ps2_wdog_tick #(
  parameter int unsigned WDOG_CYCLES = 200000
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == W'(WDOG_CYCLES - 1));
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: drains the receive FIFO, folds E0/F0 prefixes, emits key events.
// Optional Pause-sequence decoding is enabled by defining PS2_E1_EN.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned WDOG_CYCLES = 200000,
  parameter int unsigned FLUSH_MAX   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            fifo_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_overflow,
  output logic                  fifo_rd,
  output logic                  watchdog,
  output logic                  err_seq,
  output logic                  err_ovf,
  ps2_kbd_ctrl_if.master        ev
);

  localparam int FW = $clog2(FLUSH_MAX + 1);

  state_e        state_q, state_d;
  logic [7:0]    byte_q, byte_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic [7:0]    code_q, code_d;
  logic          evext_q, evext_d;
  logic          evbrk_q, evbrk_d;
  logic [FW-1:0] flush_q, flush_d;
  logic          err_ovf_q, err_ovf_d;
`ifdef PS2_E1_EN
  logic          pause_q, pause_d;
  logic [2:0]    pidx_q, pidx_d;
`endif

  ps2_wdog_tick #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .tick_o (watchdog)
  );

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    code_d    = code_q;
    evext_d   = evext_q;
    evbrk_d   = evbrk_q;
    flush_d   = flush_q;
    err_ovf_d = err_ovf_q;
    fifo_rd   = 1'b0;
    err_seq   = 1'b0;
`ifdef PS2_E1_EN
    pause_d   = pause_q;
    pidx_d    = pidx_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (fifo_overflow) begin
          state_d = FLUSH;
          flush_d = '0;
        end else if (!fifo_empty) begin
          fifo_rd = 1'b1;
          byte_d  = fifo_data;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = IDLE;
        if (byte_q == PFX_EXT) begin
          ext_d = 1'b1;
        end else if (byte_q == PFX_BRK) begin
          brk_d = 1'b1;
        end else if (byte_q == CODE_ERR0 || byte_q == CODE_ERR1) begin
          err_seq = 1'b1;
          ext_d   = 1'b0;
          brk_d   = 1'b0;
`ifdef PS2_E1_EN
        end else if (byte_q == PFX_PAUSE) begin
          ext_d   = 1'b0;
          brk_d   = 1'b0;
          pidx_d  = '0;
          state_d = PAUSE;
`endif
        end else begin
          code_d  = byte_q;
          evext_d = ext_q;
          evbrk_d = brk_q;
          ext_d   = 1'b0;
          brk_d   = 1'b0;
`ifdef PS2_E1_EN
          pause_d = 1'b0;
`endif
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (ev.ev_ready) state_d = IDLE;
      end
      // The last pop of the budget ends the flush, so fifo_rd never exceeds FLUSH_MAX
      FLUSH: begin
        ext_d     = 1'b0;
        brk_d     = 1'b0;
        err_ovf_d = 1'b1;
        if (fifo_empty) begin
          state_d = IDLE;
        end else begin
          fifo_rd = 1'b1;
          flush_d = flush_q + 1'b1;
          if (flush_q == FW'(FLUSH_MAX - 1)) state_d = IDLE;
        end
      end
`ifdef PS2_E1_EN
      PAUSE: begin
        if (fifo_overflow) begin
          state_d = FLUSH;
          flush_d = '0;
        end else if (!fifo_empty) begin
          fifo_rd = 1'b1;
          if (fifo_data != pause_byte(pidx_q)) begin
            err_seq = 1'b1;
            state_d = IDLE;
          end else if (pidx_q == 3'(PAUSE_LEN - 1)) begin
            code_d  = fifo_data;
            evext_d = 1'b0;
            evbrk_d = 1'b0;
            pause_d = 1'b1;
            state_d = EMIT;
          end else begin
            pidx_d = pidx_q + 3'd1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (reset) begin
      fifo_rd = 1'b0;
      err_seq = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      byte_q    <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      code_q    <= '0;
      evext_q   <= 1'b0;
      evbrk_q   <= 1'b0;
      flush_q   <= '0;
      err_ovf_q <= 1'b0;
`ifdef PS2_E1_EN
      pause_q   <= 1'b0;
      pidx_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      code_q    <= code_d;
      evext_q   <= evext_d;
      evbrk_q   <= evbrk_d;
      flush_q   <= flush_d;
      err_ovf_q <= err_ovf_d;
`ifdef PS2_E1_EN
      pause_q   <= pause_d;
      pidx_q    <= pidx_d;
`endif
    end
  end

  assign ev.ev_valid = (state_q == EMIT);
  assign ev.ev_code  = code_q;
  assign ev.ev_ext   = evext_q;
  assign ev.ev_break = evbrk_q;
`ifdef PS2_E1_EN
  assign ev.ev_pause = pause_q;
`else
  assign ev.ev_pause = 1'b0;
`endif
  assign err_ovf = err_ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed testbench for ps2_kbd_ctrl with a behavioural receive FIFO and event monitor.
module tb_ps2_kbd_ctrl;

  localparam int WDOG = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] fifo_data;
  logic       fifo_empty, fifo_overflow, fifo_rd, watchdog, err_seq, err_ovf;

  ps2_kbd_ctrl_if evIf();

  int assertions = 0;
  int failures = 0;

  logic [7:0] fifoMem [0:63];
  int   rdPtr = 0;
  int   wrPtr = 0;
  logic ovfReq = 1'b0;
  logic ovfFlag = 1'b0;

  int rdCount = 0, errCount = 0, evCount = 0, rdWhileEmpty = 0, rdInEmit = 0;
  int cycleCnt = 0, lastWd = -1, wdPeriod = 0;
  logic [7:0] capCode [0:63];
  logic       capExt [0:63];
  logic       capBrk [0:63];
  logic       capPause [0:63];

  ps2_kbd_ctrl #(.WDOG_CYCLES(WDOG), .FLUSH_MAX(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_data     (fifo_data),
    .fifo_empty    (fifo_empty),
    .fifo_overflow (fifo_overflow),
    .fifo_rd       (fifo_rd),
    .watchdog      (watchdog),
    .err_seq       (err_seq),
    .err_ovf       (err_ovf),
    .ev            (evIf)
  );

  always #5 clk = ~clk;

  assign fifo_empty    = (rdPtr == wrPtr);
  assign fifo_data     = fifoMem[rdPtr[5:0]];
  assign fifo_overflow = ovfFlag | ovfReq;

  // Receiver FIFO model: pops on fifo_rd, any pop clears the overflow flag
  always @(posedge clk) begin
    if (fifo_rd) begin
      rdPtr   <= rdPtr + 1;
      ovfFlag <= 1'b0;
    end else if (ovfReq) begin
      ovfFlag <= 1'b1;
    end
  end

  always @(negedge clk) begin
    cycleCnt <= cycleCnt + 1;
    if (!reset) begin
      if (fifo_rd) rdCount <= rdCount + 1;
      if (fifo_rd && fifo_empty) rdWhileEmpty <= rdWhileEmpty + 1;
      if (fifo_rd && evIf.ev_valid) rdInEmit <= rdInEmit + 1;
      if (err_seq) errCount <= errCount + 1;
      if (evIf.ev_valid && evIf.ev_ready) begin
        capCode[evCount[5:0]]  <= evIf.ev_code;
        capExt[evCount[5:0]]   <= evIf.ev_ext;
        capBrk[evCount[5:0]]   <= evIf.ev_break;
        capPause[evCount[5:0]] <= evIf.ev_pause;
        evCount <= evCount + 1;
      end
      if (watchdog) begin
        if (lastWd >= 0) wdPeriod <= cycleCnt - lastWd;
        lastWd <= cycleCnt;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pushByte(input logic [7:0] b);
    fifoMem[wrPtr[5:0]] = b;
    wrPtr = wrPtr + 1;
  endtask

  task automatic waitEvents(input int target, input int budget);
    int n = 0;
    while (evCount < target && n < budget) begin
      cycles(1);
      n++;
    end
    assertions++;
    if (evCount < target) begin
      failures++;
      $display("[TB] FAIL wait_events: got %0d expected %0d", evCount, target);
    end
  endtask

  task automatic test_reset();
    evIf.ev_ready = 1'b0;
    reset = 1'b1;
    cycles(3);
    @(negedge clk);
    assertions++;
    if ({evIf.ev_valid, fifo_rd, err_seq, err_ovf, watchdog, evIf.ev_pause} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %b expected 000000",
               {evIf.ev_valid, fifo_rd, err_seq, err_ovf, watchdog, evIf.ev_pause});
    end
    assertions++;
    if ({evIf.ev_code, evIf.ev_ext, evIf.ev_break} !== 10'h0) begin
      failures++;
      $display("[TB] FAIL reset_payload: got %h expected 000", {evIf.ev_code, evIf.ev_ext, evIf.ev_break});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_single();
    int rd0, ev0;
    cycles(1);
    rd0 = rdCount;
    ev0 = evCount;
    evIf.ev_ready = 1'b1;
    pushByte(8'h1C);
    @(negedge clk);
    assertions++;
    if (fifo_rd !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_pop: got %b expected 1", fifo_rd);
    end
    @(negedge clk);
    assertions++;
    if ({fifo_rd, evIf.ev_valid} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL single_decode: got rd/valid %b expected 00", {fifo_rd, evIf.ev_valid});
    end
    @(negedge clk);
    assertions++;
    if ({evIf.ev_valid, evIf.ev_code, evIf.ev_ext, evIf.ev_break} !== {1'b1, 8'h1C, 2'b00}) begin
      failures++;
      $display("[TB] FAIL single_event: got v=%b code=%h ext=%b brk=%b expected v=1 code=1c ext=0 brk=0",
               evIf.ev_valid, evIf.ev_code, evIf.ev_ext, evIf.ev_break);
    end
    @(negedge clk);
    assertions++;
    if (evIf.ev_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_consumed: got %b expected 0", evIf.ev_valid);
    end
    cycles(2);
    assertions++;
    if (rdCount - rd0 !== 1 || fifo_empty !== 1'b1 || evCount - ev0 !== 1) begin
      failures++;
      $display("[TB] FAIL single_counts: got pops=%0d events=%0d empty=%b expected 1 1 1",
               rdCount - rd0, evCount - ev0, fifo_empty);
    end
  endtask

  task automatic test_prefix();
    int ev0, e0;
    ev0 = evCount;
    e0 = errCount;
    pushByte(8'hE0);
    pushByte(8'hF0);
    pushByte(8'h75);
    waitEvents(ev0 + 1, 40);
    cycles(8);
    assertions++;
    if (evCount !== ev0 + 1) begin
      failures++;
      $display("[TB] FAIL prefix_count: got %0d expected %0d", evCount, ev0 + 1);
    end
    assertions++;
    if ({capCode[ev0], capExt[ev0], capBrk[ev0]} !== {8'h75, 2'b11}) begin
      failures++;
      $display("[TB] FAIL prefix_ext_brk: got code=%h ext=%b brk=%b expected 75 1 1",
               capCode[ev0], capExt[ev0], capBrk[ev0]);
    end
    pushByte(8'hF0);
    pushByte(8'h1C);
    waitEvents(ev0 + 2, 40);
    cycles(4);
    assertions++;
    if ({capCode[ev0+1], capExt[ev0+1], capBrk[ev0+1]} !== {8'h1C, 2'b01}) begin
      failures++;
      $display("[TB] FAIL prefix_brk_only: got code=%h ext=%b brk=%b expected 1c 0 1",
               capCode[ev0+1], capExt[ev0+1], capBrk[ev0+1]);
    end
    assertions++;
    if (errCount !== e0) begin
      failures++;
      $display("[TB] FAIL prefix_no_err: got %0d expected %0d", errCount, e0);
    end
  endtask

  task automatic test_backpressure();
    int ev0, rdHold, n;
    logic [7:0] expCodes [0:2];
    expCodes[0] = 8'h1C;
    expCodes[1] = 8'h32;
    expCodes[2] = 8'h21;
    ev0 = evCount;
    evIf.ev_ready = 1'b0;
    pushByte(8'h1C);
    pushByte(8'h32);
    pushByte(8'h21);
    n = 0;
    while (evIf.ev_valid !== 1'b1 && n < 20) begin
      cycles(1);
      n++;
    end
    assertions++;
    if (evIf.ev_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_valid_timeout: got %b expected 1", evIf.ev_valid);
    end
    rdHold = rdCount;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      assertions++;
      if ({evIf.ev_valid, evIf.ev_code, fifo_rd} !== {1'b1, 8'h1C, 1'b0}) begin
        failures++;
        $display("[TB] FAIL bp_hold: got v=%b code=%h rd=%b expected 1 1c 0",
                 evIf.ev_valid, evIf.ev_code, fifo_rd);
      end
    end
    cycles(1);
    assertions++;
    if (rdCount !== rdHold) begin
      failures++;
      $display("[TB] FAIL bp_no_reads: got %0d expected %0d", rdCount, rdHold);
    end
    evIf.ev_ready = 1'b1;
    waitEvents(ev0 + 3, 40);
    for (int i = 0; i < 3; i++) begin
      assertions++;
      if (capCode[ev0+i] !== expCodes[i]) begin
        failures++;
        $display("[TB] FAIL bp_order: got %h expected %h", capCode[ev0+i], expCodes[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int ev0, rd0;
    ev0 = evCount;
    pushByte(8'hE0);
    cycles(4);
    rd0 = rdCount;
    for (int i = 0; i < 8; i++) pushByte(8'(8'h11 + i));
    pushByte(8'h1C);
    ovfReq = 1'b1;
    @(negedge clk);
    assertions++;
    if (fifo_rd !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf_priority: got %b expected 0", fifo_rd);
    end
    @(posedge clk);
    #1;
    ovfReq = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      assertions++;
      if (fifo_rd !== 1'b1) begin
        failures++;
        $display("[TB] FAIL ovf_flush_pop: got %b expected 1", fifo_rd);
      end
    end
    @(negedge clk);
    assertions++;
    if (err_ovf !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_sticky: got %b expected 1", err_ovf);
    end
    waitEvents(ev0 + 1, 30);
    cycles(5);
    assertions++;
    if (evCount !== ev0 + 1 || rdCount - rd0 !== 9) begin
      failures++;
      $display("[TB] FAIL ovf_counts: got events=%0d pops=%0d expected %0d 9", evCount, rdCount - rd0, ev0 + 1);
    end
    assertions++;
    if ({capCode[ev0], capExt[ev0], capBrk[ev0], err_ovf} !== {8'h1C, 3'b001}) begin
      failures++;
      $display("[TB] FAIL ovf_after: got code=%h ext=%b brk=%b ovf=%b expected 1c 0 0 1",
               capCode[ev0], capExt[ev0], capBrk[ev0], err_ovf);
    end
  endtask

  task automatic test_errseq_reset();
    int ev0, e0, n;
    ev0 = evCount;
    e0 = errCount;
    pushByte(8'h00);
    pushByte(8'hFF);
    cycles(10);
    assertions++;
    if (errCount - e0 !== 2 || evCount !== ev0) begin
      failures++;
      $display("[TB] FAIL errseq: got pulses=%0d events=%0d expected 2 %0d", errCount - e0, evCount, ev0);
    end
    evIf.ev_ready = 1'b0;
    pushByte(8'h1C);
    n = 0;
    while (evIf.ev_valid !== 1'b1 && n < 20) begin
      cycles(1);
      n++;
    end
    assertions++;
    if (evIf.ev_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_emit_timeout: got %b expected 1", evIf.ev_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    assertions++;
    if ({evIf.ev_valid, err_ovf, fifo_rd} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL rst_mid_event: got v/ovf/rd=%b expected 000", {evIf.ev_valid, err_ovf, fifo_rd});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    evIf.ev_ready = 1'b1;
    cycles(4);
    assertions++;
    if (evCount !== ev0 || evIf.ev_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_dropped: got events=%0d v=%b expected %0d 0", evCount, evIf.ev_valid, ev0);
    end
  endtask

  task automatic test_pause();
    int ev0, e0;
    logic [7:0] stream [0:7];
    stream = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    ev0 = evCount;
    e0 = errCount;
    for (int i = 0; i < 8; i++) pushByte(stream[i]);
`ifdef PS2_E1_EN
    waitEvents(ev0 + 1, 80);
    cycles(10);
    assertions++;
    if (evCount !== ev0 + 1 || errCount !== e0) begin
      failures++;
      $display("[TB] FAIL pause_count: got events=%0d errs=%0d expected %0d %0d", evCount, errCount, ev0 + 1, e0);
    end
    assertions++;
    if ({capCode[ev0], capPause[ev0], capExt[ev0], capBrk[ev0]} !== {8'h77, 3'b100}) begin
      failures++;
      $display("[TB] FAIL pause_event: got code=%h pause=%b ext=%b brk=%b expected 77 1 0 0",
               capCode[ev0], capPause[ev0], capExt[ev0], capBrk[ev0]);
    end
`else
    waitEvents(ev0 + 6, 120);
    cycles(10);
    assertions++;
    if (evCount !== ev0 + 6) begin
      failures++;
      $display("[TB] FAIL e1_count: got %0d expected %0d", evCount, ev0 + 6);
    end
    assertions++;
    if ({capCode[ev0], capPause[ev0]} !== {8'hE1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL e1_plain: got code=%h pause=%b expected e1 0", capCode[ev0], capPause[ev0]);
    end
    assertions++;
    if ({capCode[ev0+5], capBrk[ev0+5]} !== {8'h77, 1'b1}) begin
      failures++;
      $display("[TB] FAIL e1_tail: got code=%h brk=%b expected 77 1", capCode[ev0+5], capBrk[ev0+5]);
    end
`endif
  endtask

  task automatic test_watchdog();
    cycles(3 * WDOG + 2);
    assertions++;
    if (wdPeriod !== WDOG || lastWd < 0) begin
      failures++;
      $display("[TB] FAIL wdog_period: got %0d expected %0d", wdPeriod, WDOG);
    end
  endtask

  task automatic test_invariants();
    assertions++;
    if (rdWhileEmpty !== 0) begin
      failures++;
      $display("[TB] FAIL rd_while_empty: got %0d expected 0", rdWhileEmpty);
    end
    assertions++;
    if (rdInEmit !== 0) begin
      failures++;
      $display("[TB] FAIL rd_in_emit: got %0d expected 0", rdInEmit);
    end
  endtask

  initial begin
    evIf.ev_ready = 1'b0;
    test_reset();
    test_single();
    test_prefix();
    test_backpressure();
    test_overflow();
    test_errseq_reset();
    test_pause();
    test_watchdog();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
